// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor controller.
// Holds the controller state enum and the counter width function.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
// Purely combinational; the controller carries the borrow between cycles.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller driving one fs_cell LSB-first.
// Computes a - b - bin over WIDTH cycles; diff/bout update only on completion.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           st;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [WIDTH-1:0] sd_nx;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;

  fs_cell u_cell (
    .x (sa[0]),
    .y (sb[0]),
    .bi(br),
    .d (d),
    .bo(bo)
  );

  // Written bitwise so WIDTH=1 needs no reversed slice.
  always_comb begin
    sd_nx = sd >> 1;
    sd_nx[WIDTH-1] = d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st   <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      sa   <= '0;
      sb   <= '0;
      sd   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (st)
        IDLE, DONE: begin
          if (start) begin
            sa   <= a;
            sb   <= b;
            br   <= bin;
            cnt  <= '0;
            busy <= 1'b1;
            st   <= RUN;
          end else begin
            st <= IDLE;
          end
        end
        RUN: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= sd_nx;
          br  <= bo;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            diff <= sd_nx;
            bout <= bo;
            busy <= 1'b0;
            done <= 1'b1;
            st   <= DONE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl at WIDTH=8 and WIDTH=1 against a behavioural model.
// Directed scenarios plus randomized traffic, compared every cycle.
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst8, start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       rst1, start1, bin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int errs = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .start(start8),
    .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8),
    .diff(diff8), .bout(bout8)
  );

  serial_sub_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst1), .start(start1),
    .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1),
    .diff(diff1), .bout(bout1)
  );

  typedef struct {
    bit      busy;
    bit      done;
    longint  diff;
    bit      bout;
    int      left;
    longint  res;
    bit      bo;
  } mdl_t;

  mdl_t m8 = '{0, 0, 0, 0, 0, 0, 0};
  mdl_t m1 = '{0, 0, 0, 0, 0, 0, 0};

  // Operation-level model: result by arithmetic, timing by a countdown.
  function automatic mdl_t step(mdl_t m, bit r, bit s,
                                longint a, longint b, bit bi, int w);
    longint mask;
    mask = (longint'(1) << w) - 1;
    if (r) begin
      m = '{0, 0, 0, 0, 0, 0, 0};
    end else if (!m.busy) begin
      m.done = 0;
      if (s) begin
        m.busy = 1;
        m.left = w;
        m.res  = (a - b - bi) & mask;
        m.bo   = (a < b + bi);
      end
    end else begin
      m.left--;
      if (m.left == 0) begin
        m.busy = 0;
        m.done = 1;
        m.diff = m.res;
        m.bout = m.bo;
      end
    end
    return m;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%0h required=%0h @%0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    m8 = step(m8, rst8, start8, a8, b8, bin8, 8);
    m1 = step(m1, rst1, start1, a1, b1, bin1, 1);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy8", busy8, m8.busy);
      chk("done8", done8, m8.done);
      chk("diff8", diff8, m8.diff);
      chk("bout8", bout8, m8.bout);
      chk("busy1", busy1, m1.busy);
      chk("done1", done1, m1.done);
      chk("diff1", diff1, m1.diff);
      chk("bout1", bout1, m1.bout);
    end
  end

  task automatic wait_done(output int n);
    n = 0;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("done8_timeout", 0, 1);
  endtask

  task automatic launch(input logic [7:0] a, input logic [7:0] b,
                        input logic bi);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    bin8 = bi;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b,
                    input logic bi, input logic [7:0] ed,
                    input logic eb, input string nm);
    int n;
    launch(a, b, bi);
    wait_done(n);
    chk({nm, "_lat"}, n, 8);
    chk({nm, "_diff"}, diff8, ed);
    chk({nm, "_bout"}, bout8, eb);
    chk({nm, "_mdl"}, m8.diff, ed);
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_bout", bout8, 0);
    rst8 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    start1 = 1'b1; a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    chk("w1_busy", busy1, 1);
    @(negedge clk);
    chk("w1_done", done1, 1);
    chk("w1_diff", diff1, 1);
    chk("w1_bout", bout1, 1);
    @(negedge clk);

    op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "basic");
    op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "bin_uf");
    op(8'h3C, 8'h5A, 1'b0, 8'hE2, 1'b1, "uf");

    launch(8'h10, 8'h01, 1'b0);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    chk("hold_diff", diff8, 8'hE2);
    wait_done(n);
    chk("ign_lat", n, 6);
    chk("ign_diff", diff8, 8'h0F);
    chk("ign_bout", bout8, 0);

    launch(8'h80, 8'h01, 1'b0);
    wait_done(n);
    chk("b2b_lat", n, 8);
    chk("b2b_diff", diff8, 8'h7F);
    chk("b2b_bout", bout8, 0);
    @(negedge clk);

    launch(8'hAA, 8'h55, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst8 = 1'b1;
    start8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    start8 = 1'b0;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_diff", diff8, 0);
    chk("abort_bout", bout8, 0);
    repeat (12) @(negedge clk);
    op(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, "post_rst");

    for (int i = 0; i < 3000; i++) begin
      rst8   = ($urandom_range(0, 199) == 0);
      start8 = ($urandom_range(0, 2) == 0);
      a8     = 8'($urandom);
      b8     = 8'($urandom);
      bin8   = 1'($urandom);
      rst1   = ($urandom_range(0, 99) == 0);
      start1 = ($urandom_range(0, 1) == 0);
      a1     = 1'($urandom);
      b1     = 1'($urandom);
      bin1   = 1'($urandom);
      @(negedge clk);
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
